distortion_sequencer: RTL and testbench



---
 rtl/distortion_sequencer.sv | 134 +++++++++++++
 tb/tb_distortion_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/distortion_sequencer.sv
// rtl/distortion_sequencer.sv - stereo distortion sequencer sharing one multiply/clip datapath
// Config is shadowed and applied at frame start; gain ramps toward the pending target per frame.
module distortion_sequencer #(
    parameter int GAIN_MAX  = 128,
    parameter int RAMP_STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] leftSampleIn,
    input  logic signed [15:0] rightSampleIn,
    input  logic               sampleValid,
    output logic signed [15:0] leftSampleOut,
    output logic signed [15:0] rightSampleOut,
    output logic               sampleReady,
    output logic               busy,
    output logic               overrun,
    input  logic signed [15:0] gainTarget,
    input  logic signed [31:0] threshold,
    input  logic [1:0]         mode,
    input  logic               cfgLoad,
    output logic signed [15:0] gainActive
);

    typedef enum logic [2:0] {IDLE, MUL_L, CLIP_L, MUL_R, CLIP_R, DONE} state_t;

    localparam logic signed [15:0] STEP16 = 16'(RAMP_STEP);
    localparam logic signed [16:0] STEP17 = 17'(RAMP_STEP);

    state_t             state, state_next;
    logic signed [15:0] lat_l, lat_r, res_l;
    logic [1:0]         act_mode, pend_mode;
    logic signed [31:0] act_thr, pend_thr;
    logic signed [15:0] pend_gain;
    logic signed [31:0] product;

    logic signed [15:0] mul_a, clip_sample, clip_result, gain_ramped, cfg_gain;
    logic signed [31:0] mul_p, neg_thr, cfg_thr;
    logic signed [16:0] gain_diff;
    logic               ramp_en;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sampleValid) state_next = MUL_L;
            MUL_L:   state_next = CLIP_L;
            CLIP_L:  state_next = MUL_R;
            MUL_R:   state_next = CLIP_R;
            CLIP_R:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One multiplier and one clip unit, steered by the current channel phase
    always_comb begin
        mul_a       = (state == MUL_R) ? lat_r : lat_l;
        mul_p       = 32'(mul_a) * 32'(gainActive);
        clip_sample = (state == CLIP_R) ? lat_r : lat_l;
        neg_thr     = -act_thr;
        clip_result = clip_sample;
        case (act_mode)
            2'd1: begin
                if (product > act_thr)      clip_result = act_thr[15:0];
                else if (product < neg_thr) clip_result = neg_thr[15:0];
                else                        clip_result = product[15:0];
            end
            2'd2:    if (clip_sample[15]) clip_result = '0;
            default: ;
        endcase
    end

    always_comb begin
        gain_diff = 17'(pend_gain) - 17'(gainActive);
        if (gain_diff > STEP17)       gain_ramped = gainActive + STEP16;
        else if (gain_diff < -STEP17) gain_ramped = gainActive - STEP16;
        else                          gain_ramped = pend_gain;
        // Bypass modes freeze the ramp so it resumes where it left off
        ramp_en = (pend_mode == 2'd1) || (pend_mode == 2'd2);

        if (gainTarget < 0)             cfg_gain = '0;
        else if (gainTarget > GAIN_MAX) cfg_gain = 16'(GAIN_MAX);
        else                            cfg_gain = gainTarget;
        if (threshold < 0)              cfg_thr = '0;
        else if (threshold > 32'sd32767) cfg_thr = 32'sd32767;
        else                            cfg_thr = threshold;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lat_l          <= '0;
            lat_r          <= '0;
            res_l          <= '0;
            act_mode       <= 2'd0;
            act_thr        <= 32'sd32767;
            pend_mode      <= 2'd0;
            pend_thr       <= 32'sd32767;
            pend_gain      <= 16'sd1;
            gainActive     <= 16'sd1;
            product        <= '0;
            leftSampleOut  <= '0;
            rightSampleOut <= '0;
            overrun        <= 1'b0;
        end else begin
            state <= state_next;
            if (cfgLoad) begin
                pend_gain <= cfg_gain;
                pend_thr  <= cfg_thr;
                pend_mode <= mode;
            end
            if (sampleValid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (sampleValid) begin
                    lat_l    <= leftSampleIn;
                    lat_r    <= rightSampleIn;
                    act_mode <= pend_mode;
                    act_thr  <= pend_thr;
                    if (ramp_en) gainActive <= gain_ramped;
                end
                MUL_L, MUL_R: product <= mul_p;
                CLIP_L:       res_l <= clip_result;
                CLIP_R: begin
                    leftSampleOut  <= res_l;
                    rightSampleOut <= clip_result;
                end
                default: ;
            endcase
        end
    end

    assign sampleReady = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_distortion_sequencer.sv
// tb/tb_distortion_sequencer.sv - scoreboard bench for distortion_sequencer
module tb_distortion_sequencer;
    localparam int GAIN_MAX  = 128;
    localparam int RAMP_STEP = 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] leftSampleIn = '0, rightSampleIn = '0;
    logic               sampleValid = 1'b0;
    logic signed [15:0] leftSampleOut, rightSampleOut;
    logic               sampleReady, busy, overrun;
    logic signed [15:0] gainTarget = '0;
    logic signed [31:0] threshold = '0;
    logic [1:0]         mode = '0;
    logic               cfgLoad = 1'b0;
    logic signed [15:0] gainActive;

    distortion_sequencer #(.GAIN_MAX(GAIN_MAX), .RAMP_STEP(RAMP_STEP)) dut (
        .clk(clk), .reset(reset),
        .leftSampleIn(leftSampleIn), .rightSampleIn(rightSampleIn), .sampleValid(sampleValid),
        .leftSampleOut(leftSampleOut), .rightSampleOut(rightSampleOut),
        .sampleReady(sampleReady), .busy(busy), .overrun(overrun),
        .gainTarget(gainTarget), .threshold(threshold), .mode(mode),
        .cfgLoad(cfgLoad), .gainActive(gainActive)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int l;
        int r;
        int g;
        int cyc;
    } exp_t;
    exp_t q[$];

    int m_pg, m_pt, m_pm, m_ga;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int proc(input int s, input int md, input int thr, input int g);
        int p;
        case (md)
            1: begin
                p = s * g;
                if (p > thr) return thr;
                if (p < -thr) return -thr;
                return p;
            end
            2: return (s < 0) ? 0 : s;
            default: return s;
        endcase
    endfunction

    task automatic model_reset();
        m_pg = 1; m_pt = 32767; m_pm = 0; m_ga = 1;
        q.delete();
    endtask

    task automatic model_cfg(input int gt, input int th, input int md);
        m_pg = clampi(gt, 0, GAIN_MAX);
        m_pt = clampi(th, 0, 32767);
        m_pm = md;
    endtask

    task automatic model_frame(input int l, input int r);
        exp_t e;
        if (m_pm == 1 || m_pm == 2) begin
            if (m_pg > m_ga + RAMP_STEP)      m_ga = m_ga + RAMP_STEP;
            else if (m_pg < m_ga - RAMP_STEP) m_ga = m_ga - RAMP_STEP;
            else                              m_ga = m_pg;
        end
        e.l = proc(l, m_pm, m_pt, m_ga);
        e.r = proc(r, m_pm, m_pt, m_ga);
        e.g = m_ga;
        e.cyc = cyc + 5;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sampleReady) begin
            if (q.size() == 0) begin
                check("ready_with_empty_queue", int'(sampleReady), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_left", int'(leftSampleOut), e.l);
                check("out_right", int'(rightSampleOut), e.r);
                check("gain_active", int'(gainActive), e.g);
                check("ready_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_cfg(input int gt, input int th, input int md);
        model_cfg(gt, th, md);
        gainTarget = 16'(gt); threshold = 32'(th); mode = 2'(md); cfgLoad = 1'b1;
        tick();
        cfgLoad = 1'b0;
    endtask

    task automatic do_frame(input int l, input int r, input bit with_cfg, input int gt,
                            input int th, input int md, input int gap, input bit chk_busy);
        model_frame(l, r);
        if (with_cfg) begin
            model_cfg(gt, th, md);
            gainTarget = 16'(gt); threshold = 32'(th); mode = 2'(md); cfgLoad = 1'b1;
        end
        leftSampleIn = 16'(l); rightSampleIn = 16'(r); sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0; cfgLoad = 1'b0;
        for (int i = 1; i < gap; i++) begin
            if (chk_busy) check("busy_in_frame", int'(busy), int'(i <= 5));
            tick();
        end
    endtask

    initial begin
        logic signed [15:0] rs_l, rs_r;
        do_reset();
        check("reset_left", int'(leftSampleOut), 0);
        check("reset_right", int'(rightSampleOut), 0);
        check("reset_ready", int'(sampleReady), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_gain", int'(gainActive), 1);

        do_frame(1000, -2000, 0, 0, 0, 0, 7, 1);

        do_cfg(4, 10000, 1);
        for (int i = 0; i < 4; i++) do_frame(2000, -3000, 0, 0, 0, 0, 7, 1);
        check("frame4_left", int'(leftSampleOut), 8000);
        check("frame4_right", int'(rightSampleOut), -10000);

        do_cfg(128, 40000, 1);
        for (int i = 0; i < 126; i++) do_frame(-32768, 50 * i, 0, 0, 0, 0, 6, 0);
        check("full_clip_left", int'(leftSampleOut), -32767);
        do_frame(100, -100, 0, 0, 0, 0, 6, 0);
        check("gain128_left", int'(leftSampleOut), 12800);

        do_cfg(500, 0, 2);
        do_frame(-500, 700, 0, 0, 0, 0, 6, 0);
        do_cfg(-7, 0, 3);
        do_frame(-500, 700, 0, 0, 0, 0, 6, 0);
        do_frame(1, 2, 1, 60, 20000, 1, 6, 0);
        do_frame(3, 4, 0, 0, 0, 0, 6, 0);

        for (int i = 0; i < 150; i++) begin
            int gt, th, md;
            gt = int'($urandom_range(0, 400)) - 100;
            th = int'($urandom_range(0, 60000)) - 10000;
            md = int'($urandom_range(0, 3));
            rs_l = 16'($urandom());
            rs_r = 16'($urandom());
            if ($urandom_range(0, 3) == 0) do_cfg(gt, th, md);
            do_frame(int'(rs_l), int'(rs_r), $urandom_range(0, 4) == 0, gt, th, md,
                     6 + int'($urandom_range(0, 3)), 0);
        end

        check("overrun_before", int'(overrun), 0);
        do_frame(1111, -2222, 0, 0, 0, 0, 3, 1);
        leftSampleIn = 16'sd9; rightSampleIn = 16'sd9; sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        repeat (4) tick();
        check("overrun_set", int'(overrun), 1);
        do_frame(-77, 88, 0, 0, 0, 0, 7, 1);
        check("overrun_sticky", int'(overrun), 1);

        leftSampleIn = 16'sd1234; rightSampleIn = -16'sd1234; sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("midreset_ready", int'(sampleReady), 0);
        check("midreset_left", int'(leftSampleOut), 0);
        check("midreset_right", int'(rightSampleOut), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_gain", int'(gainActive), 1);
        check("midreset_overrun", int'(overrun), 0);
        repeat (10) tick();
        do_frame(-300, 300, 0, 0, 0, 0, 7, 1);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
